instr_assembler: RTL

- Inverse of the instruction field splitter: packs op/rs/rt/rd/immediate fields plus a format code into 32-bit MIPS32 words.
- Writes the packed words sequentially into instruction memory through a req/ack write port.
- Loads programs into instruction memory before the CPU is released from reset. Stops on the halt opcode or when the region is full.

---
 rtl/instr_assembler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_assembler.sv
// Packs R/I/J field tuples into MIPS32 words and streams them to instruction memory
// over a req/ack write port. Optional tuple legality checking: define ASM_CHECK_EN.
module instr_assembler #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    DEPTH      = 64,
  parameter logic [5:0]            HALT_OP    = 6'b111111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            fmt,
  input  logic [5:0]            op,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [15:0]           immediate,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] instr_count,
  output logic                  done,
  output logic                  full,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_FULL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  full_q, full_d;
  logic [31:0]           packed_word;
  logic                  accept;

  // J targets are just the concatenated rs/rt/immediate, so J and reserved pack like I.
  always_comb begin
    packed_word = {op, rs, rt, immediate};
    if (fmt == 2'd0) packed_word = {op, rs, rt, rd, immediate[10:0]};
  end

  assign in_ready = (state_q == S_IDLE) && !done_q && !full_q;
  assign accept   = in_ready && in_valid && !clr;

`ifdef ASM_CHECK_EN
  logic err_q, err_d;
  logic illegal;
  assign illegal = (fmt == 2'd3) || ((fmt == 2'd0) && (rd == 5'd0) && (op != 6'd0));
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    done_d  = done_q;
    full_d  = full_q;
`ifdef ASM_CHECK_EN
    err_d   = err_q;
`endif
    // clr never interrupts an in-flight write.
    if (clr && state_q != S_WRITE) begin
      state_d = S_IDLE;
      addr_d  = BASE_ADDR;
      count_d = '0;
      wdata_d = '0;
      req_d   = 1'b0;
      done_d  = 1'b0;
      full_d  = 1'b0;
`ifdef ASM_CHECK_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wdata_d = packed_word;
            req_d   = 1'b1;
            state_d = S_WRITE;
`ifdef ASM_CHECK_EN
            if (illegal) err_d = 1'b1;
`endif
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            req_d   = 1'b0;
            count_d = count_q + ADDR_WIDTH'(1);
            addr_d  = addr_q + ADDR_WIDTH'(4);
            if (count_d == ADDR_WIDTH'(DEPTH)) full_d = 1'b1;
            if (wdata_q[31:26] == HALT_OP) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (count_d == ADDR_WIDTH'(DEPTH)) begin
              state_d = S_FULL;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
`ifdef ASM_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      done_q  <= done_d;
      full_q  <= full_d;
`ifdef ASM_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign instr_count = count_q;
  assign done        = done_q;
  assign full        = full_q;

endmodule
